// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, default read
// data, default-slave FSM state type and small decode helpers.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] AHBL_DEFAULT_RDATA = 32'hBADD_BEEF;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

    // Base/mask region hit test.
    function automatic logic addr_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return ((addr & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// Internal default slave: produces the two-cycle AHB-Lite ERROR response
// (ERR1: not ready + ERROR, ERR2: ready + ERROR) for unmapped accesses and
// for watchdog aborts of a stalled slave. All outputs are registered.
module ahbl_default_slave
    import ahbl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic unmapped_trig_i,
    input  logic timeout_trig_i,
    output logic hreadyout_o,
    output logic hresp_o,
    output logic busy_o
);

    ds_state_e state_q;
    logic      hreadyout_q;
    logic      hresp_q;
    logic      busy_q;

    // Error-response FSM with registered ready/response/busy outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= DS_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    if (unmapped_trig_i || timeout_trig_i) begin
                        state_q     <= DS_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q     <= DS_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                        busy_q      <= 1'b0;
                    end
                end
                DS_ERR1: begin
                    state_q     <= DS_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                    busy_q      <= 1'b1;
                end
                DS_ERR2: begin
                    // The address phase accepted here may itself be unmapped
                    if (unmapped_trig_i) begin
                        state_q     <= DS_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q     <= DS_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= DS_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign hreadyout_o = hreadyout_q;
    assign hresp_o     = hresp_q;
    assign busy_o      = busy_q;

endmodule

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite 1-to-NS splitter: base/mask address decode (lowest index wins),
// data-phase select register and zero-latency response mux. Unmapped
// transfers are answered by ahbl_default_slave.
// Optional feature: define AHBL_SPLITTER_TIMEOUT_EN to enable a watchdog
// that aborts a slave holding HREADYOUT low for TIMEOUT cycles.
module ahbl_splitter_n
    import ahbl_pkg::*;
#(
    parameter int unsigned      NS      = 3,
    parameter logic [NS*32-1:0] BASE    = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NS*32-1:0] MASK    = {3{32'hF000_0000}},
    parameter int unsigned      TIMEOUT = 1024
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    output logic               HREADY,
    output logic               HRESP,
    output logic [31:0]        HRDATA,
    output logic [NS-1:0]      S_HSEL,
    input  logic [NS*32-1:0]   S_HRDATA,
    input  logic [NS-1:0]      S_HREADYOUT,
    input  logic [NS-1:0]      S_HRESP
);

    logic [NS-1:0] hsel_s;
    logic          nomatch_s;
    logic          acc_s;
    logic          unmapped_trig_s;
    logic          timeout_trig_s;

    logic [NS-1:0] sel_q;
    logic [NS-1:0] sel_d;
    logic          def_q;
    logic          def_d;

    logic          dflt_hready_s;
    logic          dflt_hresp_s;
    logic          dflt_busy_s;
    logic          dflt_sel_s;

    logic          hready_s;
    logic          hresp_s;
    logic [31:0]   hrdata_s;

    // Priority address decode: the lowest-index matching slave wins
    always_comb begin
        logic found_v;
        logic hit_v;
        hsel_s  = '0;
        found_v = 1'b0;
        hit_v   = 1'b0;
        for (int i = 0; i < NS; i++) begin
            hit_v     = addr_match(HADDR, BASE[32*i +: 32], MASK[32*i +: 32]);
            hsel_s[i] = hit_v & ~found_v;
            found_v   = found_v | hit_v;
        end
        nomatch_s = ~found_v;
    end

    assign acc_s           = trans_active(HTRANS) & hready_s;
    assign unmapped_trig_s = acc_s & nomatch_s;
    assign dflt_sel_s      = def_q | dflt_busy_s;

    // Response mux: default slave, else the selected slave, else idle OKAY
    always_comb begin
        hready_s = 1'b1;
        hresp_s  = HRESP_OKAY;
        hrdata_s = AHBL_DEFAULT_RDATA;
        if (dflt_sel_s) begin
            hready_s = dflt_hready_s;
            hresp_s  = dflt_hresp_s;
        end else if (|sel_q) begin
            hready_s = |(sel_q & S_HREADYOUT);
            hresp_s  = |(sel_q & S_HRESP);
            hrdata_s = 32'h0000_0000;
            for (int i = 0; i < NS; i++) begin
                hrdata_s = hrdata_s | (S_HRDATA[32*i +: 32] & {32{sel_q[i]}});
            end
        end else begin
            hready_s = 1'b1;
            hresp_s  = HRESP_OKAY;
            hrdata_s = AHBL_DEFAULT_RDATA;
        end
    end

`ifdef AHBL_SPLITTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            stall_s;

    assign stall_s        = ~dflt_sel_s & (|sel_q) & ~hready_s;
    assign timeout_trig_s = stall_s & (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Watchdog: count consecutive cycles a selected slave stalls the bus
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt_q <= '0;
        end else if (hready_s || timeout_trig_s) begin
            to_cnt_q <= '0;
        end else if (stall_s) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= to_cnt_q;
        end
    end
`else
    assign timeout_trig_s = 1'b0;
`endif

    // Next data-phase select: only moves when the bus is ready, or on abort
    always_comb begin
        sel_d = sel_q;
        def_d = def_q;
        if (timeout_trig_s) begin
            sel_d = '0;
            def_d = 1'b0;
        end else if (hready_s) begin
            if (acc_s) begin
                sel_d = hsel_s;
                def_d = nomatch_s;
            end else begin
                sel_d = '0;
                def_d = 1'b0;
            end
        end else begin
            sel_d = sel_q;
            def_d = def_q;
        end
    end

    // Data-phase select register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
            def_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            def_q <= def_d;
        end
    end

    ahbl_default_slave u_default_slave (
        .clk_i           (HCLK),
        .rst_i           (HRESET),
        .unmapped_trig_i (unmapped_trig_s),
        .timeout_trig_i  (timeout_trig_s),
        .hreadyout_o     (dflt_hready_s),
        .hresp_o         (dflt_hresp_s),
        .busy_o          (dflt_busy_s)
    );

    assign S_HSEL = hsel_s;
    assign HREADY = hready_s;
    assign HRESP  = hresp_s;
    assign HRDATA = hrdata_s;

endmodule
